// File: rtl/pcie_datalink_pkg.sv
// Shared PCIe data link layer definitions: DLLP type codes, sequence width,
// stream sideband tag and the Ack/Nak transmit state encoding.
package pcie_datalink_pkg;

    localparam int unsigned SEQ_NUM_WIDTH = 12;

    localparam logic [7:0] DLLP_TYPE_ACK = 8'h00;
    localparam logic [7:0] DLLP_TYPE_NAK = 8'h10;

    localparam logic [2:0] DLLP_TUSER = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } acknak_state_e;

endpackage

// File: rtl/dllp_crc16.sv
// Combinational PCIe DLLP CRC-16 (poly 0x100B, seed 0xFFFF) over one 32-bit
// DLLP header word; output is complemented and bit-mapped for bytes 4..5.
module dllp_crc16 (
    input  logic [31:0] data,
    output logic [15:0] crc
);

    logic [15:0] lfsr;
    logic [7:0]  rev_hi;
    logic [7:0]  rev_lo;

    always_comb begin
        lfsr = 16'hFFFF;
        // byte 0 first, bit 0 of each byte first
        for (int unsigned i = 0; i < 32; i++) begin
            lfsr = {lfsr[14:0], 1'b0} ^ ({16{lfsr[15] ^ data[i]}} & 16'h100B);
        end
        rev_hi = {<<{lfsr[15:8]}};
        rev_lo = {<<{lfsr[7:0]}};
        crc    = ~{rev_lo, rev_hi};
    end

endmodule

// File: rtl/dllp_acknak_scheduler.sv
// Receive-side Ack/Nak scheduler: tracks NEXT_RCV_SEQ and emits Ack/Nak DLLPs
// as two-beat AXI-Stream packets. Optional macro: ACKNAK_LATENCY_TIMER_EN.
module dllp_acknak_scheduler
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 3,
    parameter int ACK_LATENCY = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     link_active_i,
    input  logic                     tlp_rcv_vld_i,
    input  logic                     tlp_rcv_good_i,
    input  logic [SEQ_NUM_WIDTH-1:0] tlp_rcv_seq_i,
    output logic                     tlp_accept_o,
    output logic [SEQ_NUM_WIDTH-1:0] next_rcv_seq_o,
    output logic                     nak_scheduled_o,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,
    input  logic                     m_axis_tready
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("dllp_acknak_scheduler: only DATA_WIDTH 32 is supported");
    end
    if (ACK_LATENCY < 8 || ACK_LATENCY > 4095) begin : g_bad_latency
        $error("dllp_acknak_scheduler: ACK_LATENCY must be 8..4095");
    end

    acknak_state_e state, state_nxt;

    logic [SEQ_NUM_WIDTH-1:0] next_seq;
    logic [SEQ_NUM_WIDTH-1:0] pkt_seq;
    logic [SEQ_NUM_WIDTH-1:0] seq_diff;
    logic                     pkt_nak;
    logic                     nak_sched;
    logic                     ack_req;
    logic                     nak_req;
    logic                     accept_q;
    logic                     evt, behind_or_eq, in_order, dup, nak_evt;
    logic                     launch;
    logic                     ack_raise;
    logic [31:0]              beat0_word;
    logic [15:0]              crc;

    // Bad TLPs and sequence numbers ahead of NEXT_RCV_SEQ share the Nak path.
    always_comb begin
        seq_diff     = next_seq - tlp_rcv_seq_i;
        evt          = tlp_rcv_vld_i && link_active_i;
        behind_or_eq = tlp_rcv_good_i && (seq_diff <= 12'd2048);
        in_order     = evt && tlp_rcv_good_i && (seq_diff == '0);
        dup          = evt && behind_or_eq && (seq_diff != '0);
        nak_evt      = evt && !behind_or_eq && !nak_sched;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if ((ack_req || nak_req) && link_active_i) begin
                    state_nxt = BEAT0;
                    launch    = 1'b1;
                end
            end
            BEAT0: begin
                if (m_axis_tready) state_nxt = BEAT1;
            end
            BEAT1: begin
                if (m_axis_tready) begin
                    if ((ack_req || nak_req) && link_active_i) begin
                        state_nxt = BEAT0;
                        launch    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ACKNAK_LATENCY_TIMER_EN
    localparam logic [11:0] ACK_LIMIT = 12'(ACK_LATENCY);

    logic        ack_pending;
    logic        timer_on;
    logic [11:0] timer;

    // timer_on lags ack_pending by one edge so the count reads 0 on the
    // edge after ack_pending rises; it saturates at the limit until sent.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_pending <= 1'b0;
            timer_on    <= 1'b0;
            timer       <= '0;
        end else if (!link_active_i || launch) begin
            ack_pending <= in_order;
            timer_on    <= 1'b0;
            timer       <= '0;
        end else begin
            if (in_order) ack_pending <= 1'b1;
            timer_on <= ack_pending;
            if (!timer_on) timer <= '0;
            else if (timer != ACK_LIMIT) timer <= timer + 12'd1;
        end
    end

    assign ack_raise = timer_on && (timer == ACK_LIMIT) && !launch;
`else
    assign ack_raise = in_order;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            next_seq  <= '0;
            pkt_seq   <= '0;
            pkt_nak   <= 1'b0;
            nak_sched <= 1'b0;
            ack_req   <= 1'b0;
            nak_req   <= 1'b0;
            accept_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                pkt_nak <= nak_req;
                pkt_seq <= next_seq - 12'd1;
            end
            if (!link_active_i) begin
                next_seq  <= '0;
                nak_sched <= 1'b0;
                ack_req   <= 1'b0;
                nak_req   <= 1'b0;
                accept_q  <= 1'b0;
            end else begin
                accept_q <= in_order;
                if (in_order) begin
                    next_seq  <= next_seq + 12'd1;
                    nak_sched <= 1'b0;
                end else if (nak_evt) begin
                    nak_sched <= 1'b1;
                end
                // new events in the launch cycle survive for the next DLLP
                nak_req <= (nak_req && !launch) || nak_evt;
                ack_req <= (ack_req && !launch) || dup || ack_raise;
            end
        end
    end

    assign beat0_word = {pkt_seq[7:0], 4'h0, pkt_seq[11:8], 8'h00,
                         pkt_nak ? DLLP_TYPE_NAK : DLLP_TYPE_ACK};

    dllp_crc16 u_crc (
        .data (beat0_word),
        .crc  (crc)
    );

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        case (state)
            BEAT0: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = DATA_WIDTH'(beat0_word);
                m_axis_tkeep  = KEEP_WIDTH'(4'hF);
                m_axis_tuser  = USER_WIDTH'(DLLP_TUSER);
            end
            BEAT1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = DATA_WIDTH'({16'h0000, crc});
                m_axis_tkeep  = KEEP_WIDTH'(4'h3);
                m_axis_tuser  = USER_WIDTH'(DLLP_TUSER);
            end
            default: ;
        endcase
    end

    assign tlp_accept_o    = accept_q;
    assign next_rcv_seq_o  = next_seq;
    assign nak_scheduled_o = nak_sched;

endmodule

// File: tb/tb_dllp_acknak_scheduler.sv
// Self-checking bench for dllp_acknak_scheduler: directed scenarios plus
// randomized TLP results against a per-cycle behavioural model.
module tb_dllp_acknak_scheduler;

    localparam int LAT = 16;

    logic        clk = 1'b0;
    logic        rst_n, link, vld, good, tready;
    logic [11:0] seq;
    logic        accept, nak_o, tvalid, tlast;
    logic [11:0] next_o;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic [2:0]  tuser;

    int tests = 0;
    int fails = 0;

    dllp_acknak_scheduler #(
        .DATA_WIDTH  (32),
        .USER_WIDTH  (3),
        .ACK_LATENCY (LAT)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .link_active_i   (link),
        .tlp_rcv_vld_i   (vld),
        .tlp_rcv_good_i  (good),
        .tlp_rcv_seq_i   (seq),
        .tlp_accept_o    (accept),
        .next_rcv_seq_o  (next_o),
        .nak_scheduled_o (nak_o),
        .m_axis_tdata    (tdata),
        .m_axis_tkeep    (tkeep),
        .m_axis_tvalid   (tvalid),
        .m_axis_tlast    (tlast),
        .m_axis_tuser    (tuser),
        .m_axis_tready   (tready)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dllp_crc(input logic [31:0] w);
        logic [15:0] c;
        logic [15:0] o;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            fb = c[15] ^ w[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h100B;
        end
        for (int i = 0; i < 8; i++) begin
            o[7 - i]  = ~c[8 + i];
            o[15 - i] = ~c[i];
        end
        return o;
    endfunction

    function automatic logic [31:0] hdr_word(input logic is_nak, input logic [11:0] s);
        return {s[7:0], 4'h0, s[11:8], 8'h00, is_nak ? 8'h10 : 8'h00};
    endfunction

    // Behavioural model: m_beat 0 = no packet, 1 = header beat, 2 = CRC beat.
    int          m_beat = 0;
    logic        m_pkt_nak = 1'b0;
    logic [11:0] m_pkt_seq = '0;
    logic [11:0] m_next = '0;
    logic        m_nak_sched = 1'b0, m_ack_req = 1'b0, m_nak_req = 1'b0;
    logic        m_ack_pend = 1'b0, m_accept = 1'b0;
    longint      m_edge = 0, m_pend_edge = 0;

    always @(posedge clk) begin
        logic        launch, expire;
        logic [11:0] diff;
        if (!rst_n) begin
            m_beat = 0; m_pkt_nak = 0; m_pkt_seq = '0; m_next = '0;
            m_nak_sched = 0; m_ack_req = 0; m_nak_req = 0; m_ack_pend = 0; m_accept = 0;
        end else begin
            launch = 1'b0;
            if (m_beat == 0) launch = (m_ack_req || m_nak_req) && link;
            else if (m_beat == 1) begin if (tready) m_beat = 2; end
            else if (tready) begin
                if ((m_ack_req || m_nak_req) && link) launch = 1'b1;
                else m_beat = 0;
            end
`ifdef ACKNAK_LATENCY_TIMER_EN
            expire = m_ack_pend && (m_edge >= m_pend_edge + LAT + 2) && !launch;
`else
            expire = 1'b0;
`endif
            if (launch) begin
                m_beat    = 1;
                m_pkt_nak = m_nak_req;
                m_pkt_seq = m_next - 12'd1;
                m_ack_req = 0;
                m_ack_pend = 0;
                if (m_pkt_nak) m_nak_req = 0;
            end
            m_accept = 0;
            if (!link) begin
                m_next = '0; m_nak_sched = 0; m_ack_req = 0; m_nak_req = 0; m_ack_pend = 0;
            end else begin
                if (expire) m_ack_req = 1;
                if (vld) begin
                    diff = m_next - seq;
                    if (good && diff == 0) begin
                        m_accept = 1;
                        m_next = m_next + 12'd1;
                        m_nak_sched = 0;
`ifdef ACKNAK_LATENCY_TIMER_EN
                        if (!m_ack_pend) begin m_ack_pend = 1; m_pend_edge = m_edge; end
`else
                        m_ack_req = 1;
`endif
                    end else if (good && diff <= 12'd2048) begin
                        m_ack_req = 1;
                    end else if (!m_nak_sched) begin
                        m_nak_req = 1;
                        m_nak_sched = 1;
                    end
                end
            end
        end
        m_edge++;
    end

    always @(negedge clk) begin
        logic [31:0] ed;
        if (m_beat == 1) ed = hdr_word(m_pkt_nak, m_pkt_seq);
        else if (m_beat == 2) ed = {16'h0000, dllp_crc(hdr_word(m_pkt_nak, m_pkt_seq))};
        else ed = '0;
        chk("tvalid", 32'(tvalid), 32'(m_beat != 0));
        chk("tdata", tdata, ed);
        chk("tkeep", 32'(tkeep), m_beat == 1 ? 32'hF : m_beat == 2 ? 32'h3 : 32'h0);
        chk("tlast", 32'(tlast), 32'(m_beat == 2));
        chk("tuser", 32'(tuser), m_beat != 0 ? 32'(pcie_datalink_pkg::DLLP_TUSER) : 32'h0);
        chk("next_rcv_seq", 32'(next_o), 32'(m_next));
        chk("nak_scheduled", 32'(nak_o), 32'(m_nak_sched));
        chk("tlp_accept", 32'(accept), 32'(m_accept));
    end

    int          dllp_cnt = 0, nak_cnt = 0;
    logic [31:0] last_b0 = '0, last_b1 = '0;
    logic [3:0]  last_k1 = '0;

    always @(posedge clk) begin
        if (rst_n && tvalid && tready) begin
            if (tlast) begin
                dllp_cnt++;
                last_b1 = tdata;
                last_k1 = tkeep;
            end else begin
                last_b0 = tdata;
                if (tdata[7:0] == 8'h10) nak_cnt++;
            end
        end
    end

    task automatic send_tlp(input logic g, input logic [11:0] s);
        @(negedge clk);
        vld = 1'b1; good = g; seq = s;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while (!(m_beat == 0 && !m_ack_req && !m_nak_req && !m_ack_pend) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wait_quiet_timeout", 32'(n >= 400), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid_timeout", 32'(tvalid), 32'h1);
    endtask

    initial begin
        int          c0, r, ld;
        logic [31:0] d0;
        rst_n = 0; link = 0; vld = 0; good = 0; seq = '0; tready = 1;
        repeat (3) @(negedge clk);
        chk("reset_tvalid", 32'(tvalid), 32'h0);
        chk("reset_tdata", tdata, 32'h0);
        chk("reset_next", 32'(next_o), 32'h0);
        chk("reset_nak", 32'(nak_o), 32'h0);
        rst_n = 1; link = 1;
        repeat (2) @(negedge clk);

        // in-order 0,1,2
        c0 = dllp_cnt;
        send_tlp(1, 12'd0); repeat (3) @(negedge clk);
        send_tlp(1, 12'd1); repeat (3) @(negedge clk);
        send_tlp(1, 12'd2);
        wait_quiet();
        chk("inorder_next", 32'(next_o), 32'd3);
        chk("inorder_b0", last_b0, 32'h02000000);
        chk("inorder_crc", last_b1, {16'h0000, dllp_crc(32'h02000000)});
        chk("inorder_keep1", 32'(last_k1), 32'h3);
`ifdef ACKNAK_LATENCY_TIMER_EN
        chk("inorder_acks", 32'(dllp_cnt - c0), 32'd1);
`else
        chk("inorder_acks", 32'(dllp_cnt - c0), 32'd3);
`endif

        // bad LCRC, repeated bad, duplicate, recovery
        send_tlp(1, 12'd3); repeat (3) @(negedge clk);
        send_tlp(1, 12'd4);
        wait_quiet();
        chk("bad_pre_next", 32'(next_o), 32'd5);
        c0 = dllp_cnt;
        send_tlp(0, 12'd5);
        wait_quiet();
        chk("nak_b0", last_b0, 32'h04000010);
        chk("nak_flag", 32'(nak_o), 32'h1);
        chk("nak_count", 32'(dllp_cnt - c0), 32'd1);
        c0 = dllp_cnt;
        send_tlp(0, 12'd5);
        wait_quiet();
        chk("second_bad_none", 32'(dllp_cnt - c0), 32'd0);
        send_tlp(1, 12'd2);
        wait_quiet();
        chk("dup_b0", last_b0, 32'h04000000);
        chk("dup_count", 32'(dllp_cnt - c0), 32'd1);
        send_tlp(1, 12'd5);
        wait_quiet();
        chk("recover_nak", 32'(nak_o), 32'h0);
        chk("recover_next", 32'(next_o), 32'd6);

        // wrap: clear via link, then stream 0..4094
        @(negedge clk); link = 0;
        repeat (2) @(negedge clk); link = 1;
        chk("linkdown_next", 32'(next_o), 32'd0);
        for (int i = 0; i < 4095; i++) begin
            @(negedge clk);
            vld = 1; good = 1; seq = 12'(i);
        end
        @(negedge clk); vld = 0;
        wait_quiet();
        chk("wrap_pre_next", 32'(next_o), 32'd4095);
        send_tlp(1, 12'hFFF);
        wait_quiet();
        chk("wrap_next", 32'(next_o), 32'd0);
        chk("wrap_b0", last_b0, 32'hFF0F0000);

        // backpressure with duplicates arriving during the stall
        c0 = dllp_cnt;
        @(negedge clk); tready = 0;
        send_tlp(1, 12'hFFF);
        wait_valid();
        d0 = tdata;
        chk("bp_b0", d0, 32'hFF0F0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stable", tdata, d0);
            chk("bp_valid", 32'(tvalid), 32'h1);
            vld = (i == 2 || i == 4 || i == 6); good = 1; seq = 12'hFFD + 12'(i % 3);
        end
        vld = 0; tready = 1;
        wait_quiet();
        chk("bp_dllps", 32'(dllp_cnt - c0), 32'd2);

        // randomized traffic
        ld = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tready = ($urandom_range(0, 3) != 0);
            if (ld > 0) begin
                ld--;
                link = (ld == 0);
            end else if ($urandom_range(0, 150) == 0) begin
                link = 0;
                ld = $urandom_range(1, 4);
            end
            vld = ($urandom_range(0, 2) == 0);
            good = ($urandom_range(0, 4) != 0);
            r = $urandom_range(0, 3);
            if (r < 2) seq = m_next;
            else if (r == 2) seq = m_next - 12'($urandom_range(1, 2048));
            else seq = m_next + 12'($urandom_range(1, 2047));
        end
        @(negedge clk);
        vld = 0; link = 1; tready = 1;
        wait_quiet();

        // asynchronous reset in the middle of a stalled packet
        @(negedge clk); tready = 0;
        send_tlp(1, m_next - 12'd1);
        wait_valid();
        #2 rst_n = 0;
        #1;
        chk("arst_tvalid", 32'(tvalid), 32'h0);
        chk("arst_tlast", 32'(tlast), 32'h0);
        chk("arst_tdata", tdata, 32'h0);
        chk("arst_tkeep", 32'(tkeep), 32'h0);
        chk("arst_tuser", 32'(tuser), 32'h0);
        chk("arst_next", 32'(next_o), 32'h0);
        chk("arst_nak", 32'(nak_o), 32'h0);
        chk("arst_accept", 32'(accept), 32'h0);
        @(negedge clk);
        rst_n = 1; tready = 1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
